// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with per-port burst credits
module wrr_arbiter #(
    parameter int PORTS    = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORTS-1:0]          request,
    input  logic [PORTS-1:0]          acknowledge,
    input  logic [PORTS*WEIGHT_W-1:0] weight,
    output logic [PORTS-1:0]          grant,
    output logic                      grant_valid,
    output logic [$clog2(PORTS)-1:0]  grant_encoded,
    output logic [WEIGHT_W-1:0]       grant_credit
);
    localparam int IDX_W = $clog2(PORTS);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;
    localparam logic [IDX_W-1:0]    LAST_RESET = IDX_W'(PORTS - 1);
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);
    localparam logic [PORTS-1:0]    GRANT_ONE  = {{(PORTS-1){1'b0}}, 1'b1};

    logic [0:0]          state;
    logic [IDX_W-1:0]    last;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [WEIGHT_W-1:0] sel_weight;
    logic [WEIGHT_W-1:0] sel_credit;
    logic                owner_req;
    logic                owner_ack;
    logic                release_grant;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int step);
        int t;
        t = int'(base) + step;
        if (t >= PORTS) t = t - PORTS;
        return IDX_W'(t);
    endfunction

    // Scan upward from last+1 so the previous owner ends up lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last;
        for (int k = 1; k <= PORTS; k++) begin
            if (!sel_found && request[wrap_add(last, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(last, k);
            end
        end
        sel_weight = weight[int'(sel_idx)*WEIGHT_W +: WEIGHT_W];
        sel_credit = (sel_weight == '0) ? CREDIT_ONE : sel_weight;
    end

    // Owner dropping its request abandons the burst regardless of acknowledge.
    always_comb begin
        owner_req     = request[grant_encoded];
        owner_ack     = acknowledge[grant_encoded];
        release_grant = !owner_req || (owner_ack && grant_credit == CREDIT_ONE);
    end

    assign grant_valid = (state == ST_GRANTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_encoded <= '0;
            grant_credit  <= '0;
            last          <= LAST_RESET;
        end else if (state == ST_IDLE || release_grant) begin
            if (sel_found) begin
                state         <= ST_GRANTED;
                grant         <= GRANT_ONE << sel_idx;
                grant_encoded <= sel_idx;
                grant_credit  <= sel_credit;
                last          <= sel_idx;
            end else begin
                state         <= ST_IDLE;
                grant         <= '0;
                grant_encoded <= '0;
                grant_credit  <= '0;
            end
        end else if (owner_ack && grant_credit > CREDIT_ONE) begin
            grant_credit <= grant_credit - CREDIT_ONE;
        end
    end
endmodule
